// File: rtl/dtw_core_sched.sv
// DTW PE-array sequencer: query intake, reference sweep, pipeline drain and score latch.
// Optional completion interrupt is enabled by defining DTW_SCHED_IRQ_EN.
module dtw_core_sched #(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH   = 15,
   parameter int unsigned QUERY_LEN    = 250,
   parameter int unsigned REF_RD_LAT   = 1,
   parameter int unsigned PIPE_DEPTH   = 4,
   parameter int unsigned SCORE_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             dtw_cr,
   input  logic [31:0]             dtw_ref_len,
   output logic [31:0]             dtw_sr,
   input  logic [SAMPLE_WIDTH-1:0] q_tdata,
   input  logic                    q_tvalid,
   output logic                    q_tready,
   output logic                    ref_en,
   output logic [ADDR_WIDTH-1:0]   ref_addr,
   output logic [SAMPLE_WIDTH-1:0] pe_query,
   output logic                    pe_valid,
   output logic                    pe_first_row,
   output logic                    pe_last_col,
   input  logic [SCORE_WIDTH-1:0]  pe_score,
   input  logic [ADDR_WIDTH-1:0]   pe_pos,
   output logic [SCORE_WIDTH-1:0]  dtw_score,
   output logic [ADDR_WIDTH-1:0]   dtw_pos,
   output logic                    irq
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT_Q = 2'd1;
   localparam logic [1:0] S_SWEEP  = 2'd2;
   localparam logic [1:0] S_DRAIN  = 2'd3;

   localparam int unsigned DRAIN_LEN = REF_RD_LAT + PIPE_DEPTH;
   localparam int unsigned DCW       = $clog2(DRAIN_LEN + 1);
   localparam logic [32:0] MAX_LEN   = 33'd1 << ADDR_WIDTH;

   logic [1:0]              r_state;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH-1:0]   r_last;
   logic [15:0]             r_qcnt;
   logic [DCW-1:0]          r_dcnt;
   logic                    r_done;
   logic                    r_len_err;
   logic                    r_aborted;
   logic [SAMPLE_WIDTH-1:0] r_query;
   logic [SCORE_WIDTH-1:0]  r_score;
   logic [ADDR_WIDTH-1:0]   r_pos;
   logic [31:0]             r_sr;
   logic [REF_RD_LAT-1:0]   r_vld_sr;
   logic [REF_RD_LAT-1:0]   r_first_sr;
   logic [REF_RD_LAT-1:0]   r_lastc_sr;

   logic                    w_start;
   logic                    w_abort;
   logic                    w_len_ok;
   logic                    w_ref_en;
   logic                    w_at_last;
   logic                    w_idle_start;
   logic                    w_drain_end;
   logic [15:0]             w_qcnt_nxt;
   logic [REF_RD_LAT:0]     w_vld_in;
   logic [REF_RD_LAT:0]     w_first_in;
   logic [REF_RD_LAT:0]     w_lastc_in;
   logic                    w_unused_cr;

   assign w_start      = dtw_cr[0];
   assign w_abort      = dtw_cr[1];
   assign w_unused_cr  = ^dtw_cr[31:2];
   assign w_len_ok     = (dtw_ref_len != 32'd0) && ({1'b0, dtw_ref_len} <= MAX_LEN);
   assign w_ref_en     = (r_state == S_SWEEP);
   assign w_at_last    = (r_addr == r_last);
   assign w_idle_start = (r_state == S_IDLE) && w_start && !w_abort;
   assign w_drain_end  = (r_state == S_DRAIN) && (r_dcnt == DCW'(DRAIN_LEN - 1));
   assign w_qcnt_nxt   = r_qcnt + 16'd1;

   // Delay lines shift toward the MSB; the new sample enters at bit 0.
   assign w_vld_in   = {r_vld_sr, w_ref_en};
   assign w_first_in = {r_first_sr, w_ref_en && (r_qcnt == 16'd0)};
   assign w_lastc_in = {r_lastc_sr, w_ref_en && w_at_last};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_last     <= '0;
         r_qcnt     <= '0;
         r_dcnt     <= '0;
         r_done     <= 1'b0;
         r_len_err  <= 1'b0;
         r_aborted  <= 1'b0;
         r_query    <= '0;
         r_score    <= '0;
         r_pos      <= '0;
         r_sr       <= '0;
         r_vld_sr   <= '0;
         r_first_sr <= '0;
         r_lastc_sr <= '0;
      end else begin
         r_sr <= {r_qcnt, 9'd0, 1'b0, r_state, r_aborted, r_len_err, r_done, (r_state != S_IDLE)};
         if (w_abort && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_aborted  <= 1'b1;
            r_done     <= 1'b0;
            r_vld_sr   <= '0;
            r_first_sr <= '0;
            r_lastc_sr <= '0;
         end else begin
            r_vld_sr   <= w_vld_in[REF_RD_LAT-1:0];
            r_first_sr <= w_first_in[REF_RD_LAT-1:0];
            r_lastc_sr <= w_lastc_in[REF_RD_LAT-1:0];
            case (r_state)
               S_IDLE: begin
                  if (w_idle_start) begin
                     if (w_len_ok) begin
                        r_done    <= 1'b0;
                        r_len_err <= 1'b0;
                        r_aborted <= 1'b0;
                        r_qcnt    <= '0;
                        r_last    <= ADDR_WIDTH'(dtw_ref_len - 32'd1);
                        r_state   <= S_WAIT_Q;
                     end else begin
                        r_len_err <= 1'b1;
                     end
                  end
               end
               S_WAIT_Q: begin
                  if (q_tvalid) begin
                     r_query <= q_tdata;
                     r_addr  <= '0;
                     r_state <= S_SWEEP;
                  end
               end
               S_SWEEP: begin
                  if (w_at_last) begin
                     r_qcnt <= w_qcnt_nxt;
                     if (w_qcnt_nxt == 16'(QUERY_LEN)) begin
                        r_dcnt  <= '0;
                        r_state <= S_DRAIN;
                     end else begin
                        r_state <= S_WAIT_Q;
                     end
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
               default: begin
                  if (w_drain_end) begin
                     r_score <= pe_score;
                     r_pos   <= pe_pos;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_dcnt <= r_dcnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

`ifdef DTW_SCHED_IRQ_EN
   logic r_irq;
   // Any abort request acknowledges a pending interrupt, even from IDLE.
   always_ff @(posedge clk) begin
      if (rst)               r_irq <= 1'b0;
      else if (w_abort)      r_irq <= 1'b0;
      else if (w_idle_start) r_irq <= !w_len_ok;
      else if (w_drain_end)  r_irq <= 1'b1;
   end
   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   assign dtw_sr       = r_sr;
   assign q_tready     = (r_state == S_WAIT_Q);
   assign ref_en       = w_ref_en;
   assign ref_addr     = r_addr;
   assign pe_query     = r_query;
   assign pe_valid     = r_vld_sr[REF_RD_LAT-1];
   assign pe_first_row = r_first_sr[REF_RD_LAT-1];
   assign pe_last_col  = r_lastc_sr[REF_RD_LAT-1];
   assign dtw_score    = r_score;
   assign dtw_pos      = r_pos;

endmodule

// File: tb/tb_dtw_core_sched.sv
// Self-checking bench for dtw_core_sched: behavioural run model plus directed literal checks.
module tb_dtw_core_sched;

   localparam int SW  = 16;
   localparam int AW  = 15;
   localparam int QL  = 2;
   localparam int LAT = 1;
   localparam int PD  = 4;
   localparam int SCW = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    dtw_cr;
   logic [31:0]    dtw_ref_len;
   logic [31:0]    dtw_sr;
   logic [SW-1:0]  q_tdata;
   logic           q_tvalid;
   logic           q_tready;
   logic           ref_en;
   logic [AW-1:0]  ref_addr;
   logic [SW-1:0]  pe_query;
   logic           pe_valid;
   logic           pe_first_row;
   logic           pe_last_col;
   logic [SCW-1:0] pe_score;
   logic [AW-1:0]  pe_pos;
   logic [SCW-1:0] dtw_score;
   logic [AW-1:0]  dtw_pos;
   logic           irq;

   dtw_core_sched #(
      .SAMPLE_WIDTH(SW),
      .ADDR_WIDTH  (AW),
      .QUERY_LEN   (QL),
      .REF_RD_LAT  (LAT),
      .PIPE_DEPTH  (PD),
      .SCORE_WIDTH (SCW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dtw_cr      (dtw_cr),
      .dtw_ref_len (dtw_ref_len),
      .dtw_sr      (dtw_sr),
      .q_tdata     (q_tdata),
      .q_tvalid    (q_tvalid),
      .q_tready    (q_tready),
      .ref_en      (ref_en),
      .ref_addr    (ref_addr),
      .pe_query    (pe_query),
      .pe_valid    (pe_valid),
      .pe_first_row(pe_first_row),
      .pe_last_col (pe_last_col),
      .pe_score    (pe_score),
      .pe_pos      (pe_pos),
      .dtw_score   (dtw_score),
      .dtw_pos     (dtw_pos),
      .irq         (irq)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   int mode = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 waiting for a sample, 2 sweeping, 3 draining.
   int             ms, m_addr, m_len, m_q, m_left;
   bit             m_dn, m_le, m_ab, m_irq;
   logic [SW-1:0]  m_query;
   logic [SCW-1:0] m_score;
   logic [AW-1:0]  m_pos;
   logic [31:0]    m_sr;
   bit             dl_v [LAT];
   bit             dl_f [LAT];
   bit             dl_l [LAT];

   always @(posedge clk) begin
      if (rst) begin
         ms = 0; m_addr = 0; m_len = 0; m_q = 0; m_left = 0;
         m_dn = 0; m_le = 0; m_ab = 0; m_irq = 0;
         m_query = '0; m_score = '0; m_pos = '0; m_sr = '0;
         for (int j = 0; j < LAT; j++) begin dl_v[j] = 0; dl_f[j] = 0; dl_l[j] = 0; end
      end else begin
         m_sr = {16'(m_q), 9'd0, 3'(ms), m_ab, m_le, m_dn, (ms != 0)};
         for (int j = LAT - 1; j > 0; j--) begin
            dl_v[j] = dl_v[j-1]; dl_f[j] = dl_f[j-1]; dl_l[j] = dl_l[j-1];
         end
         dl_v[0] = (ms == 2);
         dl_f[0] = (ms == 2) && (m_q == 0);
         dl_l[0] = (ms == 2) && (m_addr == m_len - 1);
         if (dtw_cr[1]) m_irq = 0;
         if (dtw_cr[1] && ms != 0) begin
            ms = 0; m_ab = 1; m_dn = 0;
            for (int j = 0; j < LAT; j++) begin dl_v[j] = 0; dl_f[j] = 0; dl_l[j] = 0; end
         end else begin
            case (ms)
               0: if (dtw_cr[0] && !dtw_cr[1]) begin
                     if (dtw_ref_len >= 1 && longint'(dtw_ref_len) <= (longint'(1) << AW)) begin
                        m_dn = 0; m_le = 0; m_ab = 0; m_q = 0; m_irq = 0;
                        m_len = int'(dtw_ref_len); ms = 1;
                     end else begin
                        m_le = 1; m_irq = 1;
                     end
                  end
               1: if (q_tvalid) begin m_query = q_tdata; m_addr = 0; ms = 2; end
               2: if (m_addr == m_len - 1) begin
                     m_q++;
                     if (m_q == QL) begin ms = 3; m_left = LAT + PD; end
                     else ms = 1;
                  end else m_addr++;
               default: if (m_left == 1) begin
                     m_score = pe_score; m_pos = pe_pos; m_dn = 1; m_irq = 1; ms = 0;
                  end else m_left--;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("q_tready", q_tready, (ms == 1));
         chk("ref_en", ref_en, (ms == 2));
         if (ms == 2) chk("ref_addr", ref_addr, m_addr);
         chk("pe_valid", pe_valid, dl_v[LAT-1]);
         chk("pe_first_row", pe_first_row, dl_f[LAT-1]);
         chk("pe_last_col", pe_last_col, dl_l[LAT-1]);
         chk("pe_query", pe_query, m_query);
         chk("dtw_sr", dtw_sr, m_sr);
         chk("dtw_score", dtw_score, m_score);
         chk("dtw_pos", dtw_pos, m_pos);
`ifdef DTW_SCHED_IRQ_EN
         chk("irq", irq, m_irq);
`else
         chk("irq", irq, 1'b0);
`endif
      end
   end

   // Recorder for the directed scenarios.
   bit rec = 1'b0;
   int addr_q[$];
   bit f_q[$];
   bit l_q[$];
   int dr_n, rdy_n, hs_n, busy_n, en_n;

   always @(negedge clk) begin
      if (rec) begin
         if (ref_en) begin addr_q.push_back(int'(ref_addr)); en_n++; end
         if (pe_valid) begin f_q.push_back(pe_first_row); l_q.push_back(pe_last_col); end
         if (dtw_sr[6:4] == 3'd3) dr_n++;
         if (q_tready) rdy_n++;
         if (q_tready && q_tvalid) hs_n++;
         if (dtw_sr[0]) busy_n++;
      end
   end

   task automatic rec_clear();
      addr_q.delete(); f_q.delete(); l_q.delete();
      dr_n = 0; rdy_n = 0; hs_n = 0; busy_n = 0; en_n = 0;
   endtask

   // Query / PE-side stimulus.
   int vcnt = 0;
   initial begin
      q_tvalid = 0; q_tdata = '0; pe_score = '0; pe_pos = '0;
      forever begin
         @(posedge clk); #1;
         vcnt++;
         case (mode)
            0: q_tvalid = 0;
            1: begin
               q_tvalid = 1; q_tdata = SW'($urandom);
               pe_score = 32'hCAFE_0001; pe_pos = 15'h1234;
            end
            2: begin
               q_tvalid = (vcnt % 4 == 0) || (vcnt % 4 == 3);
               q_tdata  = SW'($urandom);
            end
            default: begin
               q_tvalid = ($urandom_range(0, 1) == 1);
               q_tdata  = SW'($urandom);
               pe_score = $urandom;
               pe_pos   = AW'($urandom);
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_cr(input logic [31:0] v);
      dtw_cr = v; tick(); dtw_cr = '0;
   endtask

   task automatic start_run(input int len);
      dtw_ref_len = len; pulse_cr(32'd1); tick();
   endtask

   task automatic wait_done(input int bound);
      bit ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (dtw_sr[1]) begin ok = 1; break; end
      end
      chk("done_wait", ok, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit found;
      int k;
      rst = 1; dtw_cr = '0; dtw_ref_len = '0;
      tick(); chk_en = 1; tick(); tick();
      rst = 0; tick();
      @(negedge clk);
      chk("rst_sr", dtw_sr, 0);
      chk("rst_ref_en", ref_en, 0);
      chk("rst_ready", q_tready, 0);
      chk("rst_score", dtw_score, 0);

      // ref_len=3, two queries, samples always valid
      mode = 1; tick(); tick();
      rec_clear(); rec = 1;
      start_run(3);
      wait_done(200);
      tick(); tick(); rec = 0;
      chk("dir_addr_cnt", addr_q.size(), 6);
      chk("dir_pv_cnt", f_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("dir_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : -1, i % 3);
         chk($sformatf("dir_first%0d", i), (i < f_q.size()) ? f_q[i] : 1'bx, (i < 3));
         chk($sformatf("dir_last%0d", i), (i < l_q.size()) ? l_q[i] : 1'bx, (i % 3 == 2));
      end
      chk("dir_drain_cycles", dr_n, 5);
      chk("dir_wait_cycles", rdy_n, 2);
      chk("dir_score", dtw_score, 32'hCAFE_0001);
      chk("dir_pos", dtw_pos, 15'h1234);
      chk("dir_qcnt", dtw_sr[31:16], 2);
      chk("dir_done", dtw_sr[1:0], 2'b10);
`ifdef DTW_SCHED_IRQ_EN
      chk("dir_irq", irq, 1);
`endif

      // Length errors at both ends
      rec_clear(); rec = 1;
      dtw_ref_len = 0; pulse_cr(32'd1); tick();
      @(negedge clk);
      chk("len0_err", dtw_sr[2], 1);
      chk("len0_busy", dtw_sr[0], 0);
`ifdef DTW_SCHED_IRQ_EN
      chk("len0_irq", irq, 1);
`endif
      dtw_ref_len = 32769; pulse_cr(32'd1); tick();
      @(negedge clk);
      chk("lenmax_err", dtw_sr[2], 1);
      rec = 0;
      chk("len_no_ref_en", en_n, 0);
      chk("len_no_busy", busy_n, 0);

      // Abort in the middle of a sweep
      start_run(16);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ref_en && ref_addr == 10) begin found = 1; break; end
      end
      chk("abort_reach_addr10", found, 1);
      dtw_cr = 32'd2;
      @(posedge clk); #1; dtw_cr = '0;
      @(negedge clk);
      chk("abort_ref_en", ref_en, 0);
      chk("abort_pe_valid", pe_valid, 0);
      @(negedge clk);
      chk("abort_flag", dtw_sr[3], 1);
      chk("abort_busy", dtw_sr[0], 0);
      chk("abort_lenerr_clr", dtw_sr[2], 0);
      chk("abort_score_kept", dtw_score, 32'hCAFE_0001);
      tick();
      start_run(4);
      wait_done(200);
      chk("post_abort_clr", dtw_sr[3], 0);

      // Max length accepted; start while busy ignored; abort
      start_run(32768);
      @(negedge clk);
      chk("maxlen_busy", dtw_sr[0], 1);
      dtw_ref_len = 0; pulse_cr(32'd1); tick();
      @(negedge clk);
      chk("busy_start_noerr", dtw_sr[2], 0);
      chk("busy_start_busy", dtw_sr[0], 1);
      pulse_cr(32'd2); tick();
      @(negedge clk);
      chk("maxlen_aborted", dtw_sr[3], 1);

      // start+abort together in IDLE
      dtw_ref_len = 5; pulse_cr(32'd3); tick();
      @(negedge clk);
      chk("sa_idle_busy", dtw_sr[0], 0);
      chk("sa_idle_aborted", dtw_sr[3], 1);
      dtw_ref_len = 0; pulse_cr(32'd3); tick();
      @(negedge clk);
      chk("sa_idle_noerr", dtw_sr[2], 0);

      // q_tvalid 1-0-0-1 pattern
      mode = 2;
      rec_clear(); rec = 1;
      start_run(2);
      wait_done(300);
      tick(); rec = 0;
      chk("toggle_handshakes", hs_n, QL);

      // Randomized runs with aborts, spurious starts and length changes mid-run
      mode = 3;
      for (int r = 0; r < 40; r++) begin
         k = $urandom_range(0, 9);
         if (k == 0) dtw_ref_len = 0;
         else if (k == 1) dtw_ref_len = 32769 + $urandom_range(0, 100);
         else dtw_ref_len = $urandom_range(1, 24);
         pulse_cr(32'd1);
         for (int c = 0; c < 2000 && ms != 0; c++) begin
            k = $urandom_range(0, 99);
            dtw_cr = (k < 2) ? 32'd2 : (k < 5) ? 32'd1 : 32'd0;
            if (k == 50) dtw_ref_len = $urandom_range(0, 24);
            tick();
         end
         dtw_cr = '0;
         chk("rand_run_end", (ms == 0), 1);
         tick();
         if (r % 5 == 0) begin pulse_cr(32'd2); tick(); end
      end

      // Reset during DRAIN
      mode = 1;
      start_run(3);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ms == 3) begin found = 1; break; end
      end
      chk("reach_drain", found, 1);
      rst = 1; tick(); rst = 0;
      @(negedge clk);
      chk("rstd_sr", dtw_sr, 0);
      chk("rstd_ref_en", ref_en, 0);
      chk("rstd_pe_valid", pe_valid, 0);
      chk("rstd_pe_query", pe_query, 0);
      chk("rstd_score", dtw_score, 0);
      chk("rstd_pos", dtw_pos, 0);
      chk("rstd_irq", irq, 0);
      repeat (8) tick();
      @(negedge clk);
      chk("rstd_no_done", dtw_sr[1], 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
